pll_reset_sequencer: RTL
========================

Name: pll_reset_sequencer

Overview:
- Sits directly downstream of the system PLL wrapper. Consumes the PLL's asynchronous `locked` output and drives the PLL's `rst` input.
- Runs on the PLL reference clock (74.25 MHz), so it keeps working while the PLL is unlocked.
- Qualifies lock stability, retries the PLL on lock timeout, then releases per-domain reset requests in a fixed order with gaps: VRAM, then CPU/draw queue, then pixel.
- Each consuming clock domain synchronises its own `rst_out` bit locally.

Parameters:
- SYNC_STAGES, 2: flip-flop stages on `pll_locked`; legal range 2..4.
- PLL_RST_CYCLES, 16: number of cycles `pll_rst` is held high per PLL reset attempt; must be ≥1.
- LOCK_TIMEOUT_CYCLES, 74250: cycles allowed in WAIT_LOCK before a retry (1 ms at 74.25 MHz).
- LOCK_STABLE_CYCLES, 1024: consecutive cycles `locked_sync` must stay high before reset release.
- STAGE_GAP_CYCLES, 64: cycles between successive reset releases; must be ≥1.
- NUM_STAGES, 3: number of sequenced reset outputs; bit 0 is released first.

Ports:
- clk, input, 1: reference clock, 74.25 MHz.
- rst, input, 1: asynchronous, active-high reset of this block. Assertion is asynchronous; deassertion is taken synchronously by the internal logic.
- pll_locked, input, 1: PLL lock flag, asynchronous to clk.
- pll_rst, output, 1: reset to the PLL, active high.
- rst_out, output, NUM_STAGES: per-domain reset requests, active high.
- ready, output, 1: high once all stages are released and lock is held.
- lock_lost, output, 1: sticky flag, set on any loss of lock after release. Cleared only by `rst`.
- retry_count, output, 8: saturating count of lock-timeout retries.
- loss_count, output, 8: saturating count of lock losses in RELEASE or RUN.

Behaviour:
- While `rst` is asserted:
  - state = PLL_RESET, `pll_rst` = 1, `rst_out` = all ones, `ready` = 0.
  - `lock_lost` = 0, `retry_count` = 0, `loss_count` = 0.
  - All counters = 0 and all synchroniser flops = 0.
- `locked_sync` is `pll_locked` after SYNC_STAGES flops. Only `locked_sync` is used internally.
- One shared counter `cnt` is cleared on every state transition. Its width is wide enough for the maximum parameter value.
- PLL_RESET:
  - `pll_rst` = 1 and `cnt` increments.
  - When `cnt` = PLL_RST_CYCLES-1: go to WAIT_LOCK. `pll_rst` is 0 from that next cycle.
  - `locked_sync` is ignored in this state.
- WAIT_LOCK:
  - If `locked_sync` = 1: go to STABLE.
  - Else if `cnt` = LOCK_TIMEOUT_CYCLES-1: go to PLL_RESET and increment `retry_count`, saturating at 255.
  - Else `cnt` increments.
- STABLE:
  - If `locked_sync` = 0: go to WAIT_LOCK. The timeout restarts from 0; this is not a retry and not a loss.
  - Else if `cnt` = LOCK_STABLE_CYCLES-1: go to RELEASE.
  - Else `cnt` increments.
- RELEASE:
  - `stage_idx` starts at 0 and `cnt` increments each cycle.
  - When `cnt` = STAGE_GAP_CYCLES-1: clear `rst_out[stage_idx]`, reset `cnt` to 0, increment `stage_idx`.
  - When the last bit clears, go to RUN on the same edge; `ready` = 1 from the next cycle.
  - Bits already released stay low.
- RUN: holds. `rst_out` = 0 and `ready` = 1.
- Lock loss in RELEASE or RUN (`locked_sync` = 0), all on the next edge:
  - `rst_out` = all ones and `ready` = 0.
  - `lock_lost` = 1 and `loss_count` increments, saturating at 255.
  - state = PLL_RESET. This lock-loss check has priority over any stage release in the same cycle.
- `rst_out` only deasserts in release order and always asserts all bits together.
- Re-asserting `rst` mid-sequence returns the block to reset values asynchronously.
- All outputs are registered; no combinational path from `pll_locked` to any output.

Test Plan:
All scenarios use SYNC_STAGES=2, PLL_RST_CYCLES=4, LOCK_TIMEOUT_CYCLES=32, LOCK_STABLE_CYCLES=8, STAGE_GAP_CYCLES=3, NUM_STAGES=3.
- Reset values: assert `rst`, then deassert with `pll_locked`=0 -> `pll_rst`=1 for exactly 4 cycles then 0; `rst_out`=3'b111; `ready`=0; both counts 0.
- Normal bring-up: raise `pll_locked` in WAIT_LOCK -> counting from the first cycle `locked_sync`=1, `rst_out[0]` falls after 11 cycles, `rst_out[1]` after 14, `rst_out[2]` after 17, `ready`=1 after 18.
- Timeout retry: hold `pll_locked`=0 -> `pll_rst` re-pulses for 4 cycles every 36 cycles; `retry_count` goes 1, 2, 3...; force 300 retries -> `retry_count` holds at 255.
- Glitch during STABLE: drop `pll_locked` for 1 cycle after 5 stable cycles -> returns to WAIT_LOCK; `rst_out` stays 3'b111; the full 8-cycle qualification restarts; `retry_count` unchanged.
- Loss in RUN: drop `pll_locked` -> 2 sync cycles later plus 1 cycle, `rst_out`=3'b111, `ready`=0, `lock_lost`=1, `loss_count`=1, `pll_rst` pulses.
- Loss mid-RELEASE, and `rst` mid-sequence: loss after `rst_out[0]` has released -> all bits reassert and no further release occurs; assert `rst` during RELEASE -> all outputs return to reset values immediately, with no clock edge required.

Source files
------------

// File: rtl/pll_reset_sequencer.sv
// ============================================================================
// pll_reset_sequencer
// ----------------------------------------------------------------------------
// Purpose:
//   Brings the system PLL out of reset and hands out per-domain reset requests
//   once the PLL lock is trustworthy. The block runs on the PLL reference
//   clock, so it keeps running while the PLL itself is unlocked.
//
//   Sequence: PLL_RESET (pulse pll_rst) -> WAIT_LOCK (bounded wait, retry on
//   timeout) -> STABLE (lock must hold for a qualification window) ->
//   RELEASE (drop rst_out bits one at a time, bit 0 first, with a fixed gap)
//   -> RUN. Any loss of lock in RELEASE or RUN re-asserts every rst_out bit
//   and restarts the PLL.
//
// Ports:
//   clk          in   reference clock (74.25 MHz), never stops
//   rst          in   async active-high block reset
//   pll_locked   in   PLL lock flag, asynchronous to clk
//   pll_rst      out  reset to the PLL, active high
//   rst_out      out  [NUM_STAGES] per-domain reset requests, active high;
//                     each consuming domain synchronises its own bit
//   ready        out  all stages released and lock held
//   lock_lost    out  sticky: lock dropped after release began
//   retry_count  out  [8] saturating count of lock-timeout retries
//   loss_count   out  [8] saturating count of lock losses in RELEASE/RUN
//   state_dbg    out  [3] current FSM state (debug/observation only)
//
// Every output is a flop; pll_locked only reaches the logic through the
// synchroniser, so there is no combinational path from it to any output.
// ============================================================================
module pll_reset_sequencer #(
    parameter int SYNC_STAGES         = 2,      // legal 2..4
    parameter int PLL_RST_CYCLES      = 16,     // >= 1
    parameter int LOCK_TIMEOUT_CYCLES = 74250,  // 1 ms at 74.25 MHz
    parameter int LOCK_STABLE_CYCLES  = 1024,
    parameter int STAGE_GAP_CYCLES    = 64,     // >= 1
    parameter int NUM_STAGES          = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  pll_locked,
    output logic                  pll_rst,
    output logic [NUM_STAGES-1:0] rst_out,
    output logic                  ready,
    output logic                  lock_lost,
    output logic [7:0]            retry_count,
    output logic [7:0]            loss_count,
    output logic [2:0]            state_dbg
);

    // ------------------------------------------------------------------------
    // Shared counter sizing: wide enough for the largest terminal count.
    // ------------------------------------------------------------------------
    localparam int MAX_AB  = (PLL_RST_CYCLES > LOCK_TIMEOUT_CYCLES) ?
                             PLL_RST_CYCLES : LOCK_TIMEOUT_CYCLES;
    localparam int MAX_CD  = (LOCK_STABLE_CYCLES > STAGE_GAP_CYCLES) ?
                             LOCK_STABLE_CYCLES : STAGE_GAP_CYCLES;
    localparam int CNT_MAX = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(PLL_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST     = CNT_W'(STAGE_GAP_CYCLES - 1);

    localparam int               IDX_W    = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_STAGES - 1);

    typedef enum logic [2:0] {
        S_PLL_RESET = 3'd0,
        S_WAIT_LOCK = 3'd1,
        S_STABLE    = 3'd2,
        S_RELEASE   = 3'd3,
        S_RUN       = 3'd4
    } state_t;

    // ------------------------------------------------------------------------
    // Lock synchroniser. Only locked_sync is used beyond this point.
    // ------------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   locked_sync;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pll_locked};
        end
    end

    assign locked_sync = sync_q[SYNC_STAGES-1];

    // ------------------------------------------------------------------------
    // FSM state and datapath registers
    // ------------------------------------------------------------------------
    state_t                state_q,     state_d;
    logic [CNT_W-1:0]      cnt_q,       cnt_d;
    logic [IDX_W-1:0]      stage_idx_q, stage_idx_d;
    logic [NUM_STAGES-1:0] rst_out_q,   rst_out_d;
    logic                  pll_rst_q,   pll_rst_d;
    logic                  ready_q,     ready_d;
    logic                  lock_lost_q, lock_lost_d;
    logic [7:0]            retry_q,     retry_d;
    logic [7:0]            loss_q,      loss_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_PLL_RESET;
            cnt_q       <= '0;
            stage_idx_q <= '0;
            rst_out_q   <= '1;
            pll_rst_q   <= 1'b1;
            ready_q     <= 1'b0;
            lock_lost_q <= 1'b0;
            retry_q     <= '0;
            loss_q      <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            stage_idx_q <= stage_idx_d;
            rst_out_q   <= rst_out_d;
            pll_rst_q   <= pll_rst_d;
            ready_q     <= ready_d;
            lock_lost_q <= lock_lost_d;
            retry_q     <= retry_d;
            loss_q      <= loss_d;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state and output logic
    // ------------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q + CNT_W'(1);
        stage_idx_d = stage_idx_q;
        rst_out_d   = rst_out_q;
        lock_lost_d = lock_lost_q;
        retry_d     = retry_q;
        loss_d      = loss_q;

        case (state_q)
            S_PLL_RESET: begin
                // Lock is meaningless while the PLL is held in reset.
                rst_out_d = '1;
                if (cnt_q == RST_LAST) begin
                    state_d = S_WAIT_LOCK;
                end
            end

            S_WAIT_LOCK: begin
                rst_out_d = '1;
                if (locked_sync) begin
                    state_d = S_STABLE;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    state_d = S_PLL_RESET;
                    retry_d = (retry_q == 8'hFF) ? retry_q : retry_q + 8'd1;
                end
            end

            S_STABLE: begin
                // A dropout here is just an unqualified lock: go back and
                // wait again with a fresh timeout, no retry or loss counted.
                rst_out_d = '1;
                if (!locked_sync) begin
                    state_d = S_WAIT_LOCK;
                end else if (cnt_q == STABLE_LAST) begin
                    state_d     = S_RELEASE;
                    stage_idx_d = '0;
                end
            end

            S_RELEASE: begin
                // Lock loss outranks a release due on the same edge.
                if (!locked_sync) begin
                    state_d     = S_PLL_RESET;
                    rst_out_d   = '1;
                    lock_lost_d = 1'b1;
                    loss_d      = (loss_q == 8'hFF) ? loss_q : loss_q + 8'd1;
                end else if (cnt_q == GAP_LAST) begin
                    for (int i = 0; i < NUM_STAGES; i++) begin
                        if (stage_idx_q == IDX_W'(i)) begin
                            rst_out_d[i] = 1'b0;
                        end
                    end
                    cnt_d       = '0;
                    stage_idx_d = stage_idx_q + IDX_W'(1);
                    if (stage_idx_q == IDX_LAST) begin
                        state_d = S_RUN;
                    end
                end
            end

            S_RUN: begin
                cnt_d = cnt_q;
                if (!locked_sync) begin
                    state_d     = S_PLL_RESET;
                    rst_out_d   = '1;
                    lock_lost_d = 1'b1;
                    loss_d      = (loss_q == 8'hFF) ? loss_q : loss_q + 8'd1;
                end else begin
                    rst_out_d = '0;
                end
            end

            default: begin
                state_d   = S_PLL_RESET;
                rst_out_d = '1;
            end
        endcase

        // The shared counter restarts on every state change.
        if (state_d != state_q) begin
            cnt_d = '0;
        end

        // Registered from the next state so pll_rst drops on the same edge
        // that enters WAIT_LOCK and rises on the edge that re-enters
        // PLL_RESET.
        pll_rst_d = (state_d == S_PLL_RESET);

        // Ready follows RUN by one cycle and drops together with rst_out.
        ready_d = (state_q == S_RUN) && (state_d == S_RUN);
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign pll_rst     = pll_rst_q;
    assign rst_out     = rst_out_q;
    assign ready       = ready_q;
    assign lock_lost   = lock_lost_q;
    assign retry_count = retry_q;
    assign loss_count  = loss_q;
    assign state_dbg   = state_q;

endmodule
